// File: rtl/dot_accum_q9.sv
// Streaming Q6.9 multiply-accumulate with bias seed; rounds/saturates each vector to Q6.9 for the tanh stage.
// Result valid two enabled edges after the last beat; one global enable freezes the pipeline while the result is stalled.
module dot_accum_q9 #(
  parameter int ACC_W = 40,
  parameter int FRAC  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_bias,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic        out_sat
);

  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_X    = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_X    = {{(ACC_W-15){1'b1}}, {15{1'b0}}};

  logic                    en;
  logic                    beat;
  logic                    first_q;
  logic                    p_vld;
  logic                    p_last;
  logic                    p_first;
  logic signed [31:0]      p_prod;
  logic signed [15:0]      p_bias;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_n;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] r;
  logic                    sat_hi;
  logic                    sat_lo;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign beat     = in_valid && en;

  // Product stage; first_q tracks whether the next accepted beat opens a vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld   <= 1'b0;
      p_last  <= 1'b0;
      p_first <= 1'b0;
      p_prod  <= '0;
      p_bias  <= '0;
      first_q <= 1'b1;
    end else if (en) begin
      p_vld <= beat;
      if (beat) begin
        p_prod  <= 32'($signed(in_a)) * 32'($signed(in_b));
        p_last  <= in_last;
        p_first <= first_q;
        p_bias  <= in_bias;
        first_q <= in_last;
      end
    end
  end

  always_comb begin
    acc_base = p_first ? ({{(ACC_W-16){p_bias[15]}}, p_bias} <<< FRAC) : acc;
    acc_n    = acc_base + {{(ACC_W-32){p_prod[31]}}, p_prod};
    rnd      = acc_n + RND_HALF;
    r        = rnd >>> FRAC;
    sat_hi   = r > MAX_X;
    sat_lo   = r < MIN_X;
  end

  // A fresh result overrides the handshake clear, so back-to-back results keep out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_x     <= 16'h0000;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (p_vld) acc <= acc_n;
      if (p_vld && p_last) begin
        out_valid <= 1'b1;
        out_x     <= sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : r[15:0]);
        out_sat   <= sat_hi || sat_lo;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum_q9.sv
// Randomized and directed bench for dot_accum_q9 against a plain-arithmetic vector model.
module tb_dot_accum_q9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] in_bias;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic        out_sat;

  always #5 clk = ~clk;

  dot_accum_q9 #(.ACC_W(40), .FRAC(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_sat(out_sat)
  );

  typedef struct packed {
    logic        sat;
    logic [15:0] x;
  } res_t;

  res_t   exp_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  int     rdy_mode = 0;
  longint m_sum   = 0;
  bit     m_first = 1'b1;

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Exact sum -> round half up -> clamp to the 16-bit range.
  function automatic res_t model_result(input longint s);
    res_t   res;
    longint rq;
    rq = (s + 256) >>> 9;
    if (rq > 32767)       begin res.sat = 1'b1; res.x = 16'h7FFF; end
    else if (rq < -32768) begin res.sat = 1'b1; res.x = 16'h8000; end
    else                  begin res.sat = 1'b0; res.x = rq[15:0]; end
    return res;
  endfunction

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] bias, input bit last, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_bias = bias; in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check_eq("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (m_first) m_sum = longint'($signed(bias)) <<< 9;
    m_sum   = m_sum + longint'($signed(a)) * longint'($signed(b));
    m_first = last;
    if (last) exp_q.push_back(model_result(m_sum));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: every visible result is compared to the head of the expected queue.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 1, 0);
        end else begin
          check_eq("out_x", out_x, exp_q[0].x);
          check_eq("out_sat", out_sat, exp_q[0].sat);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int          len;
    bit          big;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_bias = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_x", out_x, 16'h0000);
    check_eq("rst_out_sat", out_sat, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Latency of a single-beat vector: 1.0 * 0.5
    send_beat(16'h0200, 16'h0100, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("lat_edge1_valid", out_valid, 0);
    @(negedge clk);
    check_eq("lat_edge2_valid", out_valid, 1);
    check_eq("lat_edge2_x", out_x, 16'h0100);
    @(posedge clk); #1;
    drain();

    // Four beats of 1.0*1.0 plus bias 0.25; later biases ignored
    send_beat(16'h0200, 16'h0200, 16'h0080, 1'b0, 1'b0);
    send_beat(16'h0200, 16'h0200, 16'h1234, 1'b0, 1'b0);
    send_beat(16'h0200, 16'h0200, 16'h8000, 1'b0, 1'b0);
    send_beat(16'h0200, 16'h0200, 16'h7FFF, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    check_eq("vec4_x", out_x, 16'h0880);
    @(posedge clk); #1;
    drain();

    // Saturation both directions
    send_beat(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    send_beat(16'h7FFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    send_beat(16'h8000, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    send_beat(16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    drain();

    // Rounding around half an LSB
    send_beat(16'h0001, 16'h0100, 16'h0000, 1'b1, 1'b0);
    send_beat(16'h0001, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    send_beat(16'hFFFF, 16'h0100, 16'h0000, 1'b1, 1'b0);
    send_beat(16'hFFFF, 16'h0101, 16'h0000, 1'b1, 1'b0);
    drain();

    // Backpressure: two results queued behind a stalled consumer
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(16'h0200, 16'h0200, 16'h0000, 1'b1, 1'b0);
    send_beat(16'h0100, 16'h0200, 16'h0000, 1'b1, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_held_x", out_x, 16'h0200);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();

    // Reset in the middle of a vector discards it
    send_beat(16'h0400, 16'h0400, 16'h0100, 1'b0, 1'b0);
    send_beat(16'h0400, 16'h0400, 16'h0100, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_first = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_out", out_valid, 0);
    end
    @(posedge clk); #1;
    send_beat(16'h0200, 16'h0200, 16'h0000, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    check_eq("post_rst_x", out_x, 16'h0200);
    @(posedge clk); #1;
    drain();

    // Long vector of maximum-magnitude products stresses accumulator headroom
    for (int i = 0; i < 256; i++)
      send_beat(16'h8000, 16'h8000, 16'h8000, (i == 255), 1'b0);
    drain();

    // Random vectors with random gaps and random consumer stalls
    rdy_mode = 1;
    for (int v = 0; v < 80; v++) begin
      len = $urandom_range(1, 6);
      big = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < len; i++) begin
        a = big ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
        b = big ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
        send_beat(a, b, 16'($urandom), (i == len - 1), ($urandom_range(0, 3) == 0));
      end
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
